// File: rtl/expr_pkg.sv
// Shared constants and state encoding for the expression character stream blocks.
// Imported by the encoder, the transmitter top and anything consuming its characters.
package expr_pkg;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SCLR,
        DIGIT,
        OP,
        DONE
    } state_t;

endpackage

// File: rtl/expr_stream_tx_if.sv
// Job request plus 8-bit character handshake between expr_stream_tx (master) and its user (slave).
// EXPR_TX_SINK_CLR_EN adds the sink_clr strobe used to reset the downstream recogniser.
interface expr_stream_tx_if #(
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 4
);

    logic                   start;
    logic [CNT_W-1:0]       num_terms;
    logic [4*MAX_TERMS-1:0] digits;
    logic [MAX_TERMS-2:0]   ops;
    logic                   out_ready;
    logic [7:0]             out_char;
    logic                   out_valid;
    logic                   busy;
    logic                   done;
    logic                   err;
`ifdef EXPR_TX_SINK_CLR_EN
    logic                   sink_clr;
`endif

    modport master (
        input  start, num_terms, digits, ops, out_ready,
        output out_char, out_valid, busy, done, err
`ifdef EXPR_TX_SINK_CLR_EN
        , output sink_clr
`endif
    );

    modport slave (
        output start, num_terms, digits, ops, out_ready,
        input  out_char, out_valid, busy, done, err
`ifdef EXPR_TX_SINK_CLR_EN
        , input sink_clr
`endif
    );

endinterface

// File: rtl/expr_char_enc.sv
// Combinational mapping of one expression token (digit or operator) onto its ASCII byte.
module expr_char_enc
    import expr_pkg::*;
(
    input  logic       is_op,
    input  logic       op,
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = CH_ZERO + {4'h0, digit};
        if (is_op) begin
            ascii = (op == OP_MUL) ? CH_MUL : CH_PLUS;
        end
    end

endmodule

// File: rtl/expr_stream_tx.sv
// Serialises a latched digit/operator job into ASCII characters, one per accepted handshake.
// Defining EXPR_TX_SINK_CLR_EN inserts a one-cycle sink_clr state before the first digit.
module expr_stream_tx
    import expr_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    expr_stream_tx_if.master  bus
);

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       idx;
    logic [CNT_W-1:0]       idx_nxt;
    logic [CNT_W-1:0]       num_lat;
    logic [4*MAX_TERMS-1:0] digits_lat;
    logic [MAX_TERMS-2:0]   ops_lat;
    logic                   job_ok;
    logic                   latch_job;
    logic                   err_nxt;
    logic [3:0]             cur_digit;
    logic                   cur_op;
    logic                   is_last;
    logic                   valid_int;
    logic                   xfer;
    logic [7:0]             enc_char;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
`ifdef EXPR_TX_SINK_CLR_EN
    logic                   sink_clr_q;
`endif

    // Only digits below num_terms matter; the unused upper slots may hold anything.
    always_comb begin
        job_ok = (bus.num_terms != '0) && (bus.num_terms <= CNT_W'(MAX_TERMS));
        for (int i = 0; i < MAX_TERMS; i++) begin
            if ((CNT_W'(i) < bus.num_terms) && (bus.digits[4*i +: 4] > 4'd9)) begin
                job_ok = 1'b0;
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < MAX_TERMS; i++) begin
            if (idx == CNT_W'(i)) begin
                cur_digit = digits_lat[4*i +: 4];
            end
        end
        cur_op = OP_ADD;
        for (int i = 0; i < MAX_TERMS - 1; i++) begin
            if (idx == CNT_W'(i)) begin
                cur_op = ops_lat[i];
            end
        end
    end

    expr_char_enc u_enc (
        .is_op (state == OP),
        .op    (cur_op),
        .digit (cur_digit),
        .ascii (enc_char)
    );

    assign valid_int = (state == DIGIT) || (state == OP);
    assign xfer      = valid_int && bus.out_ready;
    assign is_last   = (idx == (num_lat - CNT_W'(1)));

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        latch_job = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (job_ok) begin
                        latch_job = 1'b1;
                        idx_nxt   = '0;
`ifdef EXPR_TX_SINK_CLR_EN
                        state_nxt = SCLR;
`else
                        state_nxt = DIGIT;
`endif
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SCLR: begin
                state_nxt = DIGIT;
            end
            DIGIT: begin
                if (xfer) begin
                    state_nxt = is_last ? DONE : OP;
                end
            end
            OP: begin
                if (xfer) begin
                    idx_nxt   = idx + CNT_W'(1);
                    state_nxt = DIGIT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next-state value so they line up with the state they describe.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            idx        <= '0;
            num_lat    <= '0;
            digits_lat <= '0;
            ops_lat    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef EXPR_TX_SINK_CLR_EN
            sink_clr_q <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
            err_q  <= err_nxt;
`ifdef EXPR_TX_SINK_CLR_EN
            sink_clr_q <= (state_nxt == SCLR);
`endif
            if (latch_job) begin
                num_lat    <= bus.num_terms;
                digits_lat <= bus.digits;
                ops_lat    <= bus.ops;
            end
        end
    end

    assign bus.out_valid = valid_int;
    assign bus.out_char  = valid_int ? enc_char : 8'h00;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
`ifdef EXPR_TX_SINK_CLR_EN
    assign bus.sink_clr  = sink_clr_q;
`endif

endmodule
